// File: rtl/spi_slave_param.sv
// Oversampled SPI slave: all four modes, configurable width and bit order, gapless multi-word frames.
// Define SPI_SLV_ERR_EN to add sticky underrun/abort error flags with err_clr.
module spi_slave_param #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned LSB_FIRST   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
`ifdef SPI_SLV_ERR_EN
  ,
  input  logic                  err_clr,
  output logic                  err_underrun,
  output logic                  err_abort
`endif
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                  state, state_nxt;
  logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
  logic                    sclk_s, cs_s, mosi_s, sclk_q, cs_q;
  logic [1:0]              mode_q;
  logic [DATA_WIDTH-1:0]   tx_buf, tx_sh, rx_sh, load_word;
  logic [CNT_W-1:0]        cnt;
  logic                    cpol, cpha, lead_c, trail_c, sample_c, shift_c;
  logic                    cs_fall_c, last_sample_c, load_c, done_c;
  logic                    tx_wr_c, tx_take_c, tx_full_nxt_c;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shifted(input logic [DATA_WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rx_next(input logic [DATA_WIDTH-1:0] w, input logic b);
    return (LSB_FIRST != 0) ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
  endfunction

  // Pin synchronisers plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  assign sclk_s        = sclk_sync[SYNC_STAGES-1];
  assign cs_s          = cs_sync[SYNC_STAGES-1];
  assign mosi_s        = mosi_sync[SYNC_STAGES-1];
  assign cpol          = mode_q[1];
  assign cpha          = mode_q[0];
  assign lead_c        = (sclk_s ^ sclk_q) & (sclk_s != cpol);
  assign trail_c       = (sclk_s ^ sclk_q) & (sclk_s == cpol);
  assign sample_c      = cpha ? trail_c : lead_c;
  assign shift_c       = cpha ? lead_c : trail_c;
  assign cs_fall_c     = cs_q & ~cs_s;
  assign last_sample_c = sample_c && (cnt == CNT_W'(DATA_WIDTH - 1));
  assign load_word     = tx_ready ? '0 : tx_buf;
  assign tx_wr_c       = tx_valid & tx_ready;
  assign tx_take_c     = load_c & ~tx_ready;
  assign tx_full_nxt_c = tx_wr_c | (~tx_ready & ~tx_take_c);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A final sample coinciding with cs_n rise still completes the word
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: if (cs_fall_c) state_nxt = LOAD;
      LOAD: begin
        if (cs_s) begin
          state_nxt = IDLE;
        end else begin
          load_c    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(DATA_WIDTH)) begin
          done_c    = 1'b1;
          state_nxt = cs_s ? IDLE : LOAD;
        end else if (cs_s && !last_sample_c) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= 2'b00;
      tx_buf   <= '0;
      tx_ready <= 1'b1;
      tx_sh    <= '0;
      rx_sh    <= '0;
      cnt      <= '0;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_ready <= ~tx_full_nxt_c;
      busy     <= (state_nxt != IDLE);
      if (tx_wr_c) tx_buf <= tx_data;
      if (state == IDLE && cs_fall_c) mode_q <= mode;
      if (load_c) begin
        cnt     <= '0;
        miso_oe <= 1'b1;
        if (!cpha) begin
          miso  <= first_bit(load_word);
          tx_sh <= shifted(load_word);
        end else begin
          tx_sh <= load_word;
        end
      end
      if (state == SHIFT && state_nxt == SHIFT) begin
        if (sample_c) begin
          rx_sh <= rx_next(rx_sh, mosi_s);
          cnt   <= cnt + CNT_W'(1);
        end
        // CPHA=0: the trailing edge of the previous word's last bit lands with cnt==0
        if (shift_c && (cpha || cnt != '0)) begin
          miso  <= first_bit(tx_sh);
          tx_sh <= shifted(tx_sh);
        end
      end
      if (done_c) begin
        rx_data  <= rx_sh;
        rx_valid <= 1'b1;
        cnt      <= '0;
      end
      if (state_nxt == IDLE) begin
        miso    <= 1'b0;
        miso_oe <= 1'b0;
        cnt     <= '0;
      end
    end
  end

`ifdef SPI_SLV_ERR_EN
  logic abort_c;
  assign abort_c = (state == SHIFT) && (state_nxt == IDLE) &&
                   (cnt != CNT_W'(DATA_WIDTH)) && (cnt != '0);

  // Sticky error flags; a new event wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      err_underrun <= 1'b0;
      err_abort    <= 1'b0;
    end else begin
      if (load_c && tx_ready) err_underrun <= 1'b1;
      else if (err_clr)       err_underrun <= 1'b0;
      if (abort_c)            err_abort <= 1'b1;
      else if (err_clr)       err_abort <= 1'b0;
    end
  end
`endif

endmodule
